// File: rtl/conv_pkg.sv
// Shared defaults, index widths and state encoding for the conv-layer loop sequencer.
package conv_pkg;

  localparam int K_DEF          = 5;
  localparam int OUT_W_DEF      = 28;
  localparam int M_CH_DEF       = 6;
  localparam int N_CH_DEF       = 1;
  localparam int N_STEP_DEF     = 4;
  localparam int PIPE_DEPTH_DEF = 9;

  localparam int IDX_W  = 8;
  localparam int KIDX_W = 4;
  localparam int ADDR_W = 16;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  // The channel loop is finished when the next step would reach or pass N_CH.
  function automatic logic n_final(input logic [IDX_W-1:0] n_val, input int step, input int nch);
    return (9'(n_val) + 9'(step)) >= 9'(nch);
  endfunction

endpackage

// File: rtl/tag_delay.sv
// Reset-clearable shift pipeline that aligns write tags with the MAC result.
module tag_delay #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 9
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        always_comb stage_d[gi] = in;
      end else begin : g_tail
        always_comb stage_d[gi] = stage_q[gi-1];
      end

      always_ff @(posedge clock) begin
        if (reset) stage_q[gi] <= '0;
        else       stage_q[gi] <= stage_d[gi];
      end
    end
  endgenerate

  assign out = stage_q[DEPTH-1];

endmodule

// File: rtl/conv_loop_sequencer.sv
// Output-stationary loop-nest sequencer: issues one (m,r,c,n,i,j) tuple per cycle,
// tags first/last MAC of each pixel and delays the write tag to the MAC output.
module conv_loop_sequencer
  import conv_pkg::*;
#(
  parameter int K          = K_DEF,
  parameter int OUT_W      = OUT_W_DEF,
  parameter int M_CH       = M_CH_DEF,
  parameter int N_CH       = N_CH_DEF,
  parameter int N_STEP     = N_STEP_DEF,
  parameter int PIPE_DEPTH = PIPE_DEPTH_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  output logic [IDX_W-1:0]  m,
  output logic [IDX_W-1:0]  r,
  output logic [IDX_W-1:0]  c,
  output logic [IDX_W-1:0]  n,
  output logic [KIDX_W-1:0] i,
  output logic [KIDX_W-1:0] j,
  output logic              idx_valid,
  output logic              acc_clear,
  output logic              acc_last,
  output logic              out_wr,
  output logic [ADDR_W-1:0] out_addr,
  output logic [IDX_W-1:0]  out_chan,
  output logic              busy,
  output logic              done
);

  localparam int TAG_W = 1 + ADDR_W + IDX_W;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   m_q, m_d, r_q, r_d, c_q, c_d, n_q, n_d;
  logic [KIDX_W-1:0]  i_q, i_d, j_q, j_d;
  logic               valid_q, valid_d;
  logic               clear_q, clear_d;
  logic               last_q, last_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   drain_q, drain_d;

  logic j_wrap, i_wrap, n_wrap, c_wrap, r_wrap, m_wrap, last_tuple;
  logic [ADDR_W-1:0]  pix_addr;
  logic [TAG_W-1:0]   tag_in, tag_out;

  always_comb begin
    j_wrap     = (j_q == KIDX_W'(K - 1));
    i_wrap     = (i_q == KIDX_W'(K - 1));
    n_wrap     = n_final(n_q, N_STEP, N_CH);
    c_wrap     = (c_q == IDX_W'(OUT_W - 1));
    r_wrap     = (r_q == IDX_W'(OUT_W - 1));
    m_wrap     = (m_q == IDX_W'(M_CH - 1));
    last_tuple = j_wrap & i_wrap & n_wrap & c_wrap & r_wrap & m_wrap;
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    r_d     = r_q;
    c_d     = c_q;
    n_d     = n_q;
    i_d     = i_q;
    j_d     = j_q;
    valid_d = 1'b0;
    drain_d = drain_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          m_d     = '0;
          r_d     = '0;
          c_d     = '0;
          n_d     = '0;
          i_d     = '0;
          j_d     = '0;
          valid_d = 1'b1;
        end
      end
      RUN: begin
        if (valid_q && last_tuple) begin
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          // Advance only past a tuple that was actually issued; a stalled tuple is re-offered.
          if (valid_q) begin
            j_d = j_wrap ? '0 : j_q + 1'b1;
            if (j_wrap) begin
              i_d = i_wrap ? '0 : i_q + 1'b1;
              if (i_wrap) begin
                n_d = n_wrap ? '0 : n_q + IDX_W'(N_STEP);
                if (n_wrap) begin
                  c_d = c_wrap ? '0 : c_q + 1'b1;
                  if (c_wrap) begin
                    r_d = r_wrap ? '0 : r_q + 1'b1;
                    if (r_wrap) m_d = m_q + 1'b1;
                  end
                end
              end
            end
          end
          valid_d = !stall;
        end
      end
      DRAIN: begin
        if (drain_q == CNT_W'(PIPE_DEPTH - 1)) state_d = DONE;
        else                                   drain_d = drain_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    clear_d = valid_d & (n_d == '0) & (i_d == '0) & (j_d == '0);
    last_d  = valid_d & n_final(n_d, N_STEP, N_CH) &
              (i_d == KIDX_W'(K - 1)) & (j_d == KIDX_W'(K - 1));
    busy_d  = (state_d == RUN) || (state_d == DRAIN);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      m_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      n_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      valid_q <= 1'b0;
      clear_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      r_q     <= r_d;
      c_q     <= c_d;
      n_q     <= n_d;
      i_q     <= i_d;
      j_q     <= j_d;
      valid_q <= valid_d;
      clear_q <= clear_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    pix_addr = ADDR_W'(r_q) * ADDR_W'(OUT_W) + ADDR_W'(c_q);
    tag_in   = {last_q, pix_addr, m_q};
  end

  tag_delay #(
    .WIDTH (TAG_W),
    .DEPTH (PIPE_DEPTH)
  ) u_tag_delay (
    .clock (clock),
    .reset (reset),
    .in    (tag_in),
    .out   (tag_out)
  );

  assign m         = m_q;
  assign r         = r_q;
  assign c         = c_q;
  assign n         = n_q;
  assign i         = i_q;
  assign j         = j_q;
  assign idx_valid = valid_q;
  assign acc_clear = clear_q;
  assign acc_last  = last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign out_wr    = tag_out[TAG_W-1];
  assign out_addr  = tag_out[TAG_W-2 -: ADDR_W];
  assign out_chan  = tag_out[IDX_W-1:0];

endmodule
